// File: rtl/triangle_setup_pkg.sv
// Shared setup-stage definitions: FSM state encoding, box indices, datapath widths.
// Box indices are common with pixel_shader.
package typhoon_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDGES  = 3'd1,
        S_AREA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DIVIDE = 3'd4,
        S_DONE   = 3'd5
    } setup_state_t;

    localparam int BOX_XMIN = 0;
    localparam int BOX_YMIN = 1;
    localparam int BOX_XMAX = 2;
    localparam int BOX_YMAX = 3;

    localparam int AREA_W  = 23;
    localparam int RECIP_W = 24;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/triangle_setup_recip_divider.sv
// Serial restoring divider computing floor(2^RECIP_FRAC / divisor), MSB first.
// The start cycle already resolves the top quotient bit; the remaining bits follow while busy.
module recip_divider
    import typhoon_pkg::*;
#(
    parameter int RECIP_FRAC = 22,
    parameter int DIV_W      = AREA_W - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIV_W-1:0]      divisor,
    output logic                  busy,
    output logic [RECIP_FRAC:0]   quotient
);

    localparam int CW = $clog2(RECIP_FRAC + 1);

    logic [DIV_W-1:0] rem;
    logic [CW-1:0]    count;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   diff;
    logic             ge;

    // The dividend is a single 1 at bit RECIP_FRAC, so only the start step shifts in a 1.
    always_comb begin
        shifted = start ? {{DIV_W{1'b0}}, 1'b1} : {rem, 1'b0};
        ge      = (shifted >= {1'b0, divisor});
        diff    = ge ? (shifted - {1'b0, divisor}) : shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            rem      <= '0;
            count    <= '0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            rem      <= diff[DIV_W-1:0];
            count    <= CW'(RECIP_FRAC - 1);
            quotient <= (RECIP_FRAC + 1)'(ge);
        end else if (busy) begin
            rem      <= diff[DIV_W-1:0];
            quotient <= {quotient[RECIP_FRAC-1:0], ge};
            if (count == '0) begin
                busy <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: edge deltas, clipped bounding box, doubled signed area, area reciprocal
// and culling, presented on a held valid/ready output for the tile scheduler.
module triangle_setup
    import typhoon_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int RECIP_FRAC = 22
) (
    input  logic                      BOARD_CLK,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9:0]                x0,
    input  logic [9:0]                y0,
    input  logic [9:0]                x1,
    input  logic [9:0]                y1,
    input  logic [9:0]                x2,
    input  logic [9:0]                y2,
    input  logic [15:0]               z0,
    input  logic [15:0]               z1,
    input  logic [15:0]               z2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      culled,
    output logic signed [10:0]        x0_sx,
    output logic signed [10:0]        y0_sx,
    output logic signed [10:0]        x1_sx,
    output logic signed [10:0]        y1_sx,
    output logic signed [10:0]        x2_sx,
    output logic signed [10:0]        y2_sx,
    output logic [15:0]               z0_o,
    output logic [15:0]               z1_o,
    output logic [15:0]               z2_o,
    output logic [3:0][9:0]           box,
    output logic signed [AREA_W-1:0]  area,
    output logic signed [RECIP_W-1:0] areaRecip,
    output setup_state_t              state
);

    // Handshakes: a vertex set transfers on an edge where in_valid && in_ready (IDLE only);
    // results transfer on an edge where out_valid && out_ready (DONE only). While out_valid
    // is high every result output is held unchanged.

    localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);

    logic signed [10:0]       dx1, dy1, dx2, dy2;
    logic [9:0]               x_lo, y_lo;
    logic [10:0]              x_hi_p1, y_hi_p1;
    logic [9:0]               x_hi_clip, y_hi_clip;
    logic signed [AREA_W-1:0] prod_a, prod_b;
    logic                     cull_now;
    logic                     div_start;
    logic                     div_busy;
    logic [RECIP_FRAC:0]      div_quotient;

    always_comb begin
        x_lo      = min3(x0_sx[9:0], x1_sx[9:0], x2_sx[9:0]);
        y_lo      = min3(y0_sx[9:0], y1_sx[9:0], y2_sx[9:0]);
        x_hi_p1   = {1'b0, max3(x0_sx[9:0], x1_sx[9:0], x2_sx[9:0])} + 11'd1;
        y_hi_p1   = {1'b0, max3(y0_sx[9:0], y1_sx[9:0], y2_sx[9:0])} + 11'd1;
        x_hi_clip = (x_hi_p1 > SCREEN_W_L) ? SCREEN_W_L[9:0] : x_hi_p1[9:0];
        y_hi_clip = (y_hi_p1 > SCREEN_H_L) ? SCREEN_H_L[9:0] : y_hi_p1[9:0];
        prod_a    = AREA_W'(dx2) * AREA_W'(dy1);
        prod_b    = AREA_W'(dy2) * AREA_W'(dx1);
        // Non-positive area covers both back-facing and degenerate triangles.
        cull_now  = area[AREA_W-1] || (area == '0)
                    || ({1'b0, box[BOX_XMIN]} >= SCREEN_W_L)
                    || ({1'b0, box[BOX_YMIN]} >= SCREEN_H_L);
        div_start = (state == S_CHECK) && !cull_now;
    end

    recip_divider #(
        .RECIP_FRAC (RECIP_FRAC),
        .DIV_W      (AREA_W - 1)
    ) u_div (
        .clk      (BOARD_CLK),
        .reset    (reset),
        .start    (div_start),
        .divisor  (area[AREA_W-2:0]),
        .busy     (div_busy),
        .quotient (div_quotient)
    );

    always_ff @(posedge BOARD_CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            culled    <= 1'b0;
            x0_sx     <= '0;
            y0_sx     <= '0;
            x1_sx     <= '0;
            y1_sx     <= '0;
            x2_sx     <= '0;
            y2_sx     <= '0;
            z0_o      <= '0;
            z1_o      <= '0;
            z2_o      <= '0;
            dx1       <= '0;
            dy1       <= '0;
            dx2       <= '0;
            dy2       <= '0;
            box       <= '0;
            area      <= '0;
            areaRecip <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x0_sx    <= {1'b0, x0};
                        y0_sx    <= {1'b0, y0};
                        x1_sx    <= {1'b0, x1};
                        y1_sx    <= {1'b0, y1};
                        x2_sx    <= {1'b0, x2};
                        y2_sx    <= {1'b0, y2};
                        z0_o     <= z0;
                        z1_o     <= z1;
                        z2_o     <= z2;
                        in_ready <= 1'b0;
                        state    <= S_EDGES;
                    end
                end
                S_EDGES: begin
                    dx1           <= x1_sx - x0_sx;
                    dy1           <= y1_sx - y0_sx;
                    dx2           <= x2_sx - x0_sx;
                    dy2           <= y2_sx - y0_sx;
                    box[BOX_XMIN] <= x_lo;
                    box[BOX_YMIN] <= y_lo;
                    box[BOX_XMAX] <= x_hi_clip;
                    box[BOX_YMAX] <= y_hi_clip;
                    state         <= S_AREA;
                end
                S_AREA: begin
                    area  <= prod_a - prod_b;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    culled <= cull_now;
                    if (cull_now) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (!div_busy) begin
                        areaRecip <= RECIP_W'(div_quotient);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: culling, area/reciprocal, box clipping,
// latency, backpressure and mid-divide reset, against hand-computed values.
module tb_triangle_setup;
    import typhoon_pkg::*;

    logic               BOARD_CLK = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [9:0]         x0, y0, x1, y1, x2, y2;
    logic [15:0]        z0, z1, z2;
    logic               out_valid;
    logic               out_ready;
    logic               culled;
    logic signed [10:0] x0_sx, y0_sx, x1_sx, y1_sx, x2_sx, y2_sx;
    logic [15:0]        z0_o, z1_o, z2_o;
    logic [3:0][9:0]    box;
    logic signed [22:0] area;
    logic signed [23:0] areaRecip;
    setup_state_t       state;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 BOARD_CLK = ~BOARD_CLK;

    triangle_setup dut (
        .BOARD_CLK (BOARD_CLK), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .x0 (x0), .y0 (y0), .x1 (x1), .y1 (y1), .x2 (x2), .y2 (y2),
        .z0 (z0), .z1 (z1), .z2 (z2),
        .out_valid (out_valid), .out_ready (out_ready), .culled (culled),
        .x0_sx (x0_sx), .y0_sx (y0_sx), .x1_sx (x1_sx), .y1_sx (y1_sx),
        .x2_sx (x2_sx), .y2_sx (y2_sx),
        .z0_o (z0_o), .z1_o (z1_o), .z2_o (z2_o),
        .box (box), .area (area), .areaRecip (areaRecip), .state (state)
    );

    task automatic scramble_inputs();
        x0 = 10'($urandom_range(0, 1023)); y0 = 10'($urandom_range(0, 1023));
        x1 = 10'($urandom_range(0, 1023)); y1 = 10'($urandom_range(0, 1023));
        x2 = 10'($urandom_range(0, 1023)); y2 = 10'($urandom_range(0, 1023));
        z0 = 16'($urandom_range(0, 65535)); z1 = 16'($urandom_range(0, 65535));
        z2 = 16'($urandom_range(0, 65535));
    endtask

    // Presents one vertex set; returns #1 after the acceptance edge E0.
    task automatic send_tri(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int ax2, input int ay2, input int az0, input int az1,
                            input int az2);
        @(negedge BOARD_CLK);
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
        x2 = 10'(ax2); y2 = 10'(ay2);
        z0 = 16'(az0); z1 = 16'(az1); z2 = 16'(az2);
        in_valid = 1'b1;
        @(posedge BOARD_CLK);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Counts edges after E0 until out_valid is seen; -1 if it never comes.
    task automatic wait_out(output int edges);
        edges = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge BOARD_CLK);
            #1;
            if (out_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic check_released(input string tag);
        @(posedge BOARD_CLK);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge BOARD_CLK);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (state !== S_IDLE || in_ready !== 1'b1 || out_valid !== 1'b0 || culled !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: state=%0d in_ready=%b out_valid=%b culled=%b want 0/1/0/0",
                     state, in_ready, out_valid, culled);
        end
        n_cmp++;
        if (box !== '0 || area !== '0 || areaRecip !== '0 || x1_sx !== '0 || y2_sx !== '0
            || z0_o !== '0 || z2_o !== '0) begin
            n_bad++;
            $display("FAIL reset_data: box=%h area=%0d recip=%0d want all zero", box, area, areaRecip);
        end
    endtask

    task automatic test_front_facing();
        send_tri(0, 0, 0, 10, 10, 0, 16'h1111, 16'h2222, 16'h3333);
        wait_out(lat);
        n_cmp++;
        if (lat !== 26) begin
            n_bad++;
            $display("FAIL front_latency: got %0d want 26", lat);
        end
        n_cmp++;
        if (area !== 23'sd100 || areaRecip !== 24'sd41943 || culled !== 1'b0) begin
            n_bad++;
            $display("FAIL front_area: area=%0d recip=%0d culled=%b want 100/41943/0",
                     area, areaRecip, culled);
        end
        n_cmp++;
        if (box[BOX_XMIN] !== 10'd0 || box[BOX_YMIN] !== 10'd0 ||
            box[BOX_XMAX] !== 10'd11 || box[BOX_YMAX] !== 10'd11) begin
            n_bad++;
            $display("FAIL front_box: got %0d,%0d,%0d,%0d want 0,0,11,11",
                     box[0], box[1], box[2], box[3]);
        end
        n_cmp++;
        if (x0_sx !== 11'sd0 || y1_sx !== 11'sd10 || x2_sx !== 11'sd10 || y2_sx !== 11'sd0
            || z0_o !== 16'h1111 || z1_o !== 16'h2222 || z2_o !== 16'h3333) begin
            n_bad++;
            $display("FAIL front_vertices: y1_sx=%0d x2_sx=%0d z1=%h want 10/10/2222",
                     y1_sx, x2_sx, z1_o);
        end
        check_released("front");
    endtask

    task automatic test_back_facing();
        send_tri(0, 0, 10, 0, 0, 10, 5, 6, 7);
        wait_out(lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL back_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (area !== -23'sd100 || culled !== 1'b1) begin
            n_bad++;
            $display("FAIL back_cull: area=%0d culled=%b want -100/1", area, culled);
        end
        check_released("back");
    endtask

    task automatic test_collinear();
        send_tri(0, 0, 5, 5, 10, 10, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (lat !== 3 || area !== 23'sd0 || culled !== 1'b1) begin
            n_bad++;
            $display("FAIL collinear: lat=%0d area=%0d culled=%b want 3/0/1", lat, area, culled);
        end
        check_released("collinear");
    endtask

    task automatic test_offscreen();
        send_tri(700, 10, 700, 20, 710, 10, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (lat !== 3 || area !== 23'sd100 || culled !== 1'b1) begin
            n_bad++;
            $display("FAIL offscreen: lat=%0d area=%0d culled=%b want 3/100/1", lat, area, culled);
        end
        check_released("offscreen");
    endtask

    task automatic test_unit_area();
        send_tri(0, 0, 0, 1, 1, 0, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (lat !== 26 || area !== 23'sd1 || areaRecip !== 24'sd4194304 || culled !== 1'b0) begin
            n_bad++;
            $display("FAIL unit_area: lat=%0d area=%0d recip=%0d want 26/1/4194304",
                     lat, area, areaRecip);
        end
        n_cmp++;
        if (box[BOX_XMAX] !== 10'd2 || box[BOX_YMAX] !== 10'd2) begin
            n_bad++;
            $display("FAIL unit_box: xmax=%0d ymax=%0d want 2/2", box[2], box[3]);
        end
        check_released("unit");
    endtask

    task automatic test_clamp();
        send_tri(600, 0, 600, 100, 1000, 0, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (box[BOX_XMIN] !== 10'd600 || box[BOX_YMIN] !== 10'd0 ||
            box[BOX_XMAX] !== 10'd640 || box[BOX_YMAX] !== 10'd101) begin
            n_bad++;
            $display("FAIL clamp_box: got %0d,%0d,%0d,%0d want 600,0,640,101",
                     box[0], box[1], box[2], box[3]);
        end
        n_cmp++;
        if (culled !== 1'b0 || area !== 23'sd40000 || areaRecip !== 24'sd104) begin
            n_bad++;
            $display("FAIL clamp_area: culled=%b area=%0d recip=%0d want 0/40000/104",
                     culled, area, areaRecip);
        end
        check_released("clamp");
        send_tri(1023, 5, 1023, 9, 1000, 5, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (box[BOX_XMAX] !== 10'd640 || box[BOX_XMIN] !== 10'd1000 || culled !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_1023: xmax=%0d xmin=%0d culled=%b want 640/1000/1",
                     box[2], box[0], culled);
        end
        check_released("clamp1023");
    endtask

    task automatic test_backpressure();
        int bad_cycles;
        out_ready = 1'b0;
        send_tri(0, 0, 0, 20, 30, 0, 16'hbeef, 1, 2);
        wait_out(lat);
        n_cmp++;
        if (lat !== 26 || area !== 23'sd600 || areaRecip !== 24'sd6990) begin
            n_bad++;
            $display("FAIL bp_result: lat=%0d area=%0d recip=%0d want 26/600/6990",
                     lat, area, areaRecip);
        end
        bad_cycles = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge BOARD_CLK);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || area !== 23'sd600 ||
                areaRecip !== 24'sd6990 || box[BOX_XMAX] !== 10'd31 || box[BOX_YMAX] !== 10'd21 ||
                z0_o !== 16'hbeef || x2_sx !== 11'sd30 || culled !== 1'b0)
                bad_cycles++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad_cycles);
        end
        out_ready = 1'b1;
        check_released("bp");
    endtask

    task automatic test_reset_mid_divide();
        send_tri(0, 0, 0, 10, 10, 0, 0, 0, 0);
        repeat (9) @(posedge BOARD_CLK);
        n_cmp++;
        if (state !== S_DIVIDE) begin
            n_bad++;
            $display("FAIL mid_state: got %0d want %0d", state, S_DIVIDE);
        end
        #1;
        reset = 1'b1;
        @(posedge BOARD_CLK);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || areaRecip !== '0 || area !== '0
            || state !== S_IDLE) begin
            n_bad++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b recip=%0d area=%0d want 0/1/0/0",
                     out_valid, in_ready, areaRecip, area);
        end
        send_tri(0, 0, 0, 10, 10, 0, 0, 0, 0);
        wait_out(lat);
        n_cmp++;
        if (lat !== 26 || area !== 23'sd100 || areaRecip !== 24'sd41943 || culled !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_fresh: lat=%0d area=%0d recip=%0d want 26/100/41943",
                     lat, area, areaRecip);
        end
        check_released("mid");
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scramble_inputs();
        test_reset();
        test_front_facing();
        test_back_facing();
        test_collinear();
        test_offscreen();
        test_unit_area();
        test_clamp();
        test_backpressure();
        test_reset_mid_divide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
